noc_axi4_bridge_resp_arb: RTL and testbench

Arbitrates between the AXI4 read-response path (R channel) and the write-response path (B channel) of the NoC-AXI4 bridge. Both paths compete for the single response serializer input (header/data/val/rdy).
- Round-robin grant between the two requesters.
- One registered output stage, full-throughput (no bubble on back-to-back transfers).
- Saturating per-source grant counters for debug.
- Sits between the bridge's response-tracking logic and the response serializer.

---
 rtl/noc_axi4_bridge_resp_arb.sv | 88 ++++++++
 tb/tb_noc_axi4_bridge_resp_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/noc_axi4_bridge_resp_arb.sv
// Response arbiter for the NoC-AXI4 bridge.
// Merges the read-response (R) and write-response (B) paths onto the single
// serializer input. Round-robin grant, one registered output stage with
// full throughput, and saturating per-source grant counters for debug.
//
// state | meaning
// ------+---------------------------------------------------------------
// prio=0| read wins the next contended cycle
// prio=1| write wins the next contended cycle
module noc_axi4_bridge_resp_arb #(
  parameter int HDR_W  = 192,
  parameter int DATA_W = 512,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HDR_W-1:0]  rd_header,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_val,
  output logic              rd_rdy,
  input  logic [HDR_W-1:0]  wr_header,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_val,
  output logic              wr_rdy,
  output logic [HDR_W-1:0]  out_header,
  output logic [DATA_W-1:0] out_data,
  output logic              out_val,
  input  logic              out_rdy,
  output logic              out_src,
  output logic [CNT_W-1:0]  rd_grant_cnt,
  output logic [CNT_W-1:0]  wr_grant_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic prio;
  logic load_en;
  logic rd_gnt;
  logic wr_gnt;

  // The output register may refill in the same cycle it is drained.
  assign load_en = ~out_val | out_rdy;

  // Grants are mutually exclusive: a contended cycle is settled by prio.
  assign rd_gnt = load_en & rd_val & (~wr_val | ~prio);
  assign wr_gnt = load_en & wr_val & (~rd_val | prio);

  assign rd_rdy = rd_gnt;
  assign wr_rdy = wr_gnt;

  // Output stage and round-robin pointer; prio moves only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_header <= '0;
      out_data   <= '0;
      out_src    <= 1'b0;
      out_val    <= 1'b0;
      prio       <= 1'b0;
    end else if (rd_gnt) begin
      out_header <= rd_header;
      out_data   <= rd_data;
      out_src    <= 1'b0;
      out_val    <= 1'b1;
      prio       <= 1'b1;
    end else if (wr_gnt) begin
      out_header <= wr_header;
      out_data   <= wr_data;
      out_src    <= 1'b1;
      out_val    <= 1'b1;
      prio       <= 1'b0;
    end else if (out_val && out_rdy) begin
      // Drained with nothing to replace it; data registers keep their value.
      out_val <= 1'b0;
    end
  end

  // Debug grant counters, saturating at all-ones so they never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_grant_cnt <= '0;
      wr_grant_cnt <= '0;
    end else begin
      if (rd_gnt && (rd_grant_cnt != CNT_MAX)) rd_grant_cnt <= rd_grant_cnt + 1'b1;
      if (wr_gnt && (wr_grant_cnt != CNT_MAX)) wr_grant_cnt <= wr_grant_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_axi4_bridge_resp_arb.sv
// Directed, table-driven bench for the response arbiter, plus hand-written
// sequences for asynchronous reset and counter saturation.
module tb_noc_axi4_bridge_resp_arb;

  localparam int HDR_W  = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [HDR_W-1:0]  rd_header, wr_header, out_header;
  logic [DATA_W-1:0] rd_data, wr_data, out_data;
  logic              rd_val, rd_rdy, wr_val, wr_rdy;
  logic              out_val, out_rdy, out_src;
  logic [CNT_W-1:0]  rd_grant_cnt, wr_grant_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noc_axi4_bridge_resp_arb #(.HDR_W(HDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rd_header(rd_header), .rd_data(rd_data), .rd_val(rd_val), .rd_rdy(rd_rdy),
    .wr_header(wr_header), .wr_data(wr_data), .wr_val(wr_val), .wr_rdy(wr_rdy),
    .out_header(out_header), .out_data(out_data), .out_val(out_val),
    .out_rdy(out_rdy), .out_src(out_src),
    .rd_grant_cnt(rd_grant_cnt), .wr_grant_cnt(wr_grant_cnt)
  );

  typedef struct {
    logic              rv, wv, ordy;
    logic [HDR_W-1:0]  rh, wh;
    logic              e_rrdy, e_wrdy, e_val, e_src;
    logic [HDR_W-1:0]  e_hdr;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DATA_W-1:0] rd_d(input logic [HDR_W-1:0] h);
    return {~h, h};
  endfunction

  function automatic logic [DATA_W-1:0] wr_d(input logic [HDR_W-1:0] h);
    return {h, ~h};
  endfunction

  task automatic add(input logic rv, wv, ordy, input logic [HDR_W-1:0] rh, wh,
                     input logic err, ewr, ev, es, input logic [HDR_W-1:0] eh,
                     input logic [DATA_W-1:0] ed);
    vec_t v;
    v.rv = rv; v.wv = wv; v.ordy = ordy; v.rh = rh; v.wh = wh;
    v.e_rrdy = err; v.e_wrdy = ewr; v.e_val = ev; v.e_src = es;
    v.e_hdr = eh; v.e_data = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, wv, ordy, input logic [HDR_W-1:0] rh, wh);
    rd_val = rv; wr_val = wv; out_rdy = ordy;
    rd_header = rh; rd_data = rd_d(rh);
    wr_header = wh; wr_data = wr_d(wh);
  endtask

  int exp_rc, exp_wc;
  int cmax;

  initial begin
    cmax = (1 << CNT_W) - 1;
    //   rv wv ordy rh        wh        rrdy wrdy val src hdr       data
    add(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, '0);          // idle after reset
    add(1, 1, 1, 16'h00A1, 16'h00B1, 1, 0, 1, 0, 16'h00A1, rd_d(16'h00A1)); // contention x6
    add(1, 1, 1, 16'h00A2, 16'h00B2, 0, 1, 1, 1, 16'h00B2, wr_d(16'h00B2));
    add(1, 1, 1, 16'h00A3, 16'h00B3, 1, 0, 1, 0, 16'h00A3, rd_d(16'h00A3));
    add(1, 1, 1, 16'h00A4, 16'h00B4, 0, 1, 1, 1, 16'h00B4, wr_d(16'h00B4));
    add(1, 1, 1, 16'h00A5, 16'h00B5, 1, 0, 1, 0, 16'h00A5, rd_d(16'h00A5));
    add(1, 1, 1, 16'h00A6, 16'h00B6, 0, 1, 1, 1, 16'h00B6, wr_d(16'h00B6));
    add(1, 0, 1, 16'h00A5, 16'h0000, 1, 0, 1, 0, 16'h00A5, rd_d(16'h00A5)); // backpressure
    add(0, 1, 0, 16'h0000, 16'h00C8, 0, 0, 1, 0, 16'h00A5, rd_d(16'h00A5));
    add(0, 1, 0, 16'h0000, 16'h00C8, 0, 0, 1, 0, 16'h00A5, rd_d(16'h00A5));
    add(0, 1, 0, 16'h0000, 16'h00C8, 0, 0, 1, 0, 16'h00A5, rd_d(16'h00A5));
    add(0, 1, 0, 16'h0000, 16'h00C8, 0, 0, 1, 0, 16'h00A5, rd_d(16'h00A5));
    add(0, 1, 1, 16'h0000, 16'h00C8, 0, 1, 1, 1, 16'h00C8, wr_d(16'h00C8));
    add(0, 1, 1, 16'h0000, 16'h00D1, 0, 1, 1, 1, 16'h00D1, wr_d(16'h00D1)); // single source
    add(0, 1, 1, 16'h0000, 16'h00D2, 0, 1, 1, 1, 16'h00D2, wr_d(16'h00D2));
    add(0, 1, 1, 16'h0000, 16'h00D3, 0, 1, 1, 1, 16'h00D3, wr_d(16'h00D3));
    add(1, 1, 1, 16'h00A7, 16'h00D4, 1, 0, 1, 0, 16'h00A7, rd_d(16'h00A7)); // read wins after writes
    add(1, 1, 1, 16'h00A8, 16'h00D5, 0, 1, 1, 1, 16'h00D5, wr_d(16'h00D5));
    add(1, 0, 1, 16'h00E1, 16'h0000, 1, 0, 1, 0, 16'h00E1, rd_d(16'h00E1)); // drain
    add(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h00E1, rd_d(16'h00E1));
    add(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h00E1, rd_d(16'h00E1));

    rst = 1'b1;
    drive(0, 0, 1, '0, '0);
    #12;
    check("reset_out_val", 64'(out_val), 64'd0);
    check("reset_rd_cnt", 64'(rd_grant_cnt), 64'd0);
    check("reset_wr_cnt", 64'(wr_grant_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    exp_rc = 0;
    exp_wc = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rv, vecs[i].wv, vecs[i].ordy, vecs[i].rh, vecs[i].wh);
      #1;
      check($sformatf("v%0d_rd_rdy", i), 64'(rd_rdy), 64'(vecs[i].e_rrdy));
      check($sformatf("v%0d_wr_rdy", i), 64'(wr_rdy), 64'(vecs[i].e_wrdy));
      if (vecs[i].e_rrdy && exp_rc < cmax) exp_rc++;
      if (vecs[i].e_wrdy && exp_wc < cmax) exp_wc++;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_val", i), 64'(out_val), 64'(vecs[i].e_val));
      check($sformatf("v%0d_out_src", i), 64'(out_src), 64'(vecs[i].e_src));
      check($sformatf("v%0d_out_header", i), 64'(out_header), 64'(vecs[i].e_hdr));
      check($sformatf("v%0d_out_data", i), 64'(out_data), 64'(vecs[i].e_data));
      check($sformatf("v%0d_rd_cnt", i), 64'(rd_grant_cnt), 64'(exp_rc));
      check($sformatf("v%0d_wr_cnt", i), 64'(wr_grant_cnt), 64'(exp_wc));
    end

    // Asynchronous reset mid-cycle while an entry is held (prio=1 after read).
    @(negedge clk);
    drive(1, 0, 0, 16'h0055, '0);
    @(posedge clk);
    #1;
    check("pre_rst_out_val", 64'(out_val), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_val", 64'(out_val), 64'd0);
    check("async_rst_header", 64'(out_header), 64'd0);
    check("async_rst_rd_cnt", 64'(rd_grant_cnt), 64'd0);
    check("async_rst_wr_cnt", 64'(wr_grant_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 1, 16'h0061, 16'h0071);
    #1;
    check("post_rst_rd_rdy", 64'(rd_rdy), 64'd1);
    check("post_rst_wr_rdy", 64'(wr_rdy), 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_src", 64'(out_src), 64'd0);
    check("post_rst_header", 64'(out_header), 64'h0061);

    // Saturation: 20 read grants against a 4-bit counter.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, '0, '0);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      drive(1, 0, 1, HDR_W'(i), '0);
      @(posedge clk);
      #1;
      check($sformatf("sat_rd_cnt_%0d", i), 64'(rd_grant_cnt), 64'((i < cmax) ? i : cmax));
    end
    check("sat_wr_cnt", 64'(wr_grant_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
